// File: rtl/layer_config_queue_if.sv
// Host/stage-facing bundle of layer_config_queue: staging writes, commit, layer-done and head status.
// i_loop_mode exists only when LAYER_CFG_LOOP_EN is defined.
interface layer_config_queue_if #(
    parameter int REGISTER_WIDTH = 32,
    parameter int CFG_WORDS      = 8,
    parameter int DEPTH          = 4
);
    localparam int AW = $clog2(CFG_WORDS);
    localparam int DW = CFG_WORDS * REGISTER_WIDTH;
    localparam int LW = $clog2(DEPTH) + 1;

    logic                      i_wr_en;
    logic [AW-1:0]             i_wr_addr;
    logic [REGISTER_WIDTH-1:0] i_wr_data;
    logic                      i_commit;
    logic                      i_layer_done;
`ifdef LAYER_CFG_LOOP_EN
    logic                      i_loop_mode;
`endif
    logic [DW-1:0]             o_cfg;
    logic                      o_execution_flag;
    logic                      o_first_latching_condition;
    logic                      o_update_latching_condition;
    logic                      o_full;
    logic                      o_empty;
    logic [LW-1:0]             o_level;
    logic                      o_commit_err;
    logic [15:0]               o_layers_done;
    logic [1:0]                o_state;

    modport master (
        output i_wr_en, i_wr_addr, i_wr_data, i_commit, i_layer_done,
`ifdef LAYER_CFG_LOOP_EN
        output i_loop_mode,
`endif
        input  o_cfg, o_execution_flag, o_first_latching_condition,
        input  o_update_latching_condition, o_full, o_empty, o_level,
        input  o_commit_err, o_layers_done, o_state
    );

    modport slave (
        input  i_wr_en, i_wr_addr, i_wr_data, i_commit, i_layer_done,
`ifdef LAYER_CFG_LOOP_EN
        input  i_loop_mode,
`endif
        output o_cfg, o_execution_flag, o_first_latching_condition,
        output o_update_latching_condition, o_full, o_empty, o_level,
        output o_commit_err, o_layers_done, o_state
    );
endinterface

// File: rtl/layer_config_queue.sv
// Descriptor queue feeding a compute stage's config latch; issues first/update latch strobes.
// Optional replay mode: define LAYER_CFG_LOOP_EN to add i_loop_mode (retire rotates the head).
module layer_config_queue #(
    parameter int REGISTER_WIDTH = 32,
    parameter int CFG_WORDS      = 8,
    parameter int DEPTH          = 4
) (
    input logic             clk,
    input logic             resetn,
    layer_config_queue_if.slave bus
);
    localparam int DW = CFG_WORDS * REGISTER_WIDTH;
    localparam int PW = $clog2(DEPTH);
    localparam int LW = PW + 1;

    // i_commit and i_layer_done are single-cycle requests with no back-pressure:
    // a commit that cannot be accepted is dropped and reported on o_commit_err.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ARM  = 2'd1,
        RUN  = 2'd2
    } state_t;

    state_t        state;
    logic [DW-1:0] staging;
    logic [DW-1:0] mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [LW-1:0] level;
    logic          first_done;
    logic          first_strobe;
    logic          update_strobe;
    logic          exec_flag;
    logic          commit_err;
    logic [15:0]   layers_done;

    logic loop_mode;
    logic full;
    logic empty;
    logic retire;
    logic commit_ok;
    logic rotate;
    logic free_entry;

`ifdef LAYER_CFG_LOOP_EN
    assign loop_mode = bus.i_loop_mode;
`else
    assign loop_mode = 1'b0;
`endif

    assign full       = (level == LW'(DEPTH));
    assign empty      = (level == '0);
    assign retire     = (state == RUN) && bus.i_layer_done;
    assign commit_ok  = bus.i_commit && !full && !loop_mode;
    assign rotate     = retire && loop_mode;
    assign free_entry = retire && !loop_mode;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            staging <= '0;
        end else if (bus.i_wr_en && (int'(bus.i_wr_addr) < CFG_WORDS)) begin
            staging[int'(bus.i_wr_addr)*REGISTER_WIDTH +: REGISTER_WIDTH] <= bus.i_wr_data;
        end
    end

    // Commit and rotate never coincide: commits are rejected while looping.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (commit_ok) begin
            mem[wr_ptr] <= staging;
        end else if (rotate) begin
            mem[wr_ptr] <= mem[rd_ptr];
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            level       <= '0;
            commit_err  <= 1'b0;
            layers_done <= '0;
        end else begin
            commit_err <= bus.i_commit && !commit_ok;
            if (commit_ok || rotate) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (retire) begin
                rd_ptr      <= rd_ptr + 1'b1;
                layers_done <= layers_done + 16'd1;
            end
            case ({commit_ok, free_entry})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state         <= IDLE;
            first_done    <= 1'b0;
            first_strobe  <= 1'b0;
            update_strobe <= 1'b0;
            exec_flag     <= 1'b0;
        end else begin
            first_strobe  <= 1'b0;
            update_strobe <= 1'b0;
            case (state)
                IDLE: begin
                    if (!empty) begin
                        state         <= ARM;
                        first_strobe  <= ~first_done;
                        update_strobe <= first_done;
                        first_done    <= 1'b1;
                    end
                end
                ARM: begin
                    state     <= RUN;
                    exec_flag <= 1'b1;
                end
                RUN: begin
                    if (bus.i_layer_done) begin
                        state     <= IDLE;
                        exec_flag <= 1'b0;
                    end
                end
                default: begin
                    state     <= IDLE;
                    exec_flag <= 1'b0;
                end
            endcase
        end
    end

    assign bus.o_cfg                       = mem[rd_ptr];
    assign bus.o_execution_flag            = exec_flag;
    assign bus.o_first_latching_condition  = first_strobe;
    assign bus.o_update_latching_condition = update_strobe;
    assign bus.o_full                      = full;
    assign bus.o_empty                     = empty;
    assign bus.o_level                     = level;
    assign bus.o_commit_err                = commit_err;
    assign bus.o_layers_done               = layers_done;
    assign bus.o_state                     = state;
endmodule

// File: tb/tb_layer_config_queue.sv
// Self-checking bench for layer_config_queue: queue-level behavioural model plus directed literal checks.
// Replay-mode scenario runs only when LAYER_CFG_LOOP_EN is defined.
module tb_layer_config_queue;
    localparam int RW    = 32;
    localparam int CW    = 8;
    localparam int DEPTH = 4;
    localparam int DW    = RW * CW;
    localparam int AW    = $clog2(CW);

    logic clk    = 1'b0;
    logic resetn = 1'b0;
    bit   tb_loop = 1'b0;
    int   checks   = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    layer_config_queue_if #(.REGISTER_WIDTH(RW), .CFG_WORDS(CW), .DEPTH(DEPTH)) bus ();

    layer_config_queue #(.REGISTER_WIDTH(RW), .CFG_WORDS(CW), .DEPTH(DEPTH)) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

`ifdef LAYER_CFG_LOOP_EN
    assign bus.i_loop_mode = tb_loop;
`endif

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [RW-1:0] m_stage [CW];
    logic [DW-1:0] m_q [$];
    int            m_phase = 0;     // 0 waiting, 1 latching, 2 running
    bit            m_first_done, m_first, m_update, m_err, m_valid;
    int            m_layers;

    function automatic logic [DW-1:0] pack_stage();
        logic [DW-1:0] v;
        for (int i = 0; i < CW; i++) v[i*RW +: RW] = m_stage[i];
        return v;
    endfunction

    always @(posedge clk) begin : model
        logic [DW-1:0] snap;
        logic [DW-1:0] head;
        bit accept;
        if (!resetn) begin
            for (int i = 0; i < CW; i++) m_stage[i] = '0;
            m_q.delete();
            m_phase = 0; m_first_done = 0; m_first = 0; m_update = 0; m_err = 0;
            m_layers = 0; m_valid = 1;
        end else begin
            snap   = pack_stage();
            accept = bus.i_commit && (m_q.size() < DEPTH) && !tb_loop;
            m_err  = bus.i_commit && !accept;
            m_first = 0; m_update = 0;
            if (m_phase == 2 && bus.i_layer_done) begin
                head = m_q.pop_front();
                m_layers = (m_layers + 1) % 65536;
                if (tb_loop) m_q.push_back(head);
                m_phase = 0;
            end else if (m_phase == 1) begin
                m_phase = 2;
            end else if (m_phase == 0 && m_q.size() != 0) begin
                m_phase = 1;
                if (m_first_done) m_update = 1; else m_first = 1;
                m_first_done = 1;
            end
            if (accept) m_q.push_back(snap);
            if (bus.i_wr_en && int'(bus.i_wr_addr) < CW) m_stage[int'(bus.i_wr_addr)] = bus.i_wr_data;
        end
    end

    always @(negedge clk) begin
        if (m_valid) begin
            chk("level",   DW'(bus.o_level),          DW'(m_q.size()));
            chk("empty",   DW'(bus.o_empty),          DW'(m_q.size() == 0));
            chk("full",    DW'(bus.o_full),           DW'(m_q.size() == DEPTH));
            chk("layers",  DW'(bus.o_layers_done),    DW'(m_layers));
            chk("cerr",    DW'(bus.o_commit_err),     DW'(m_err));
            chk("first",   DW'(bus.o_first_latching_condition),  DW'(m_first));
            chk("update",  DW'(bus.o_update_latching_condition), DW'(m_update));
            chk("flag",    DW'(bus.o_execution_flag), DW'(m_phase == 2));
            if (m_phase != 0) chk("cfg", bus.o_cfg, m_q[0]);
        end
    end

    // Strobe log: {first, update, word0}
    logic [33:0] obs_q [$];
    always @(negedge clk) begin
        if (resetn && (bus.o_first_latching_condition || bus.o_update_latching_condition))
            obs_q.push_back({bus.o_first_latching_condition, bus.o_update_latching_condition, bus.o_cfg[31:0]});
    end

    // ---------------- driver tasks ----------------
    task automatic wr(input int a, input logic [RW-1:0] d);
        bus.i_wr_en = 1'b1; bus.i_wr_addr = AW'(a); bus.i_wr_data = d;
        @(negedge clk);
        bus.i_wr_en = 1'b0;
    endtask

    task automatic commit1();
        bus.i_commit = 1'b1;
        @(negedge clk);
        bus.i_commit = 1'b0;
    endtask

    task automatic push_desc(input logic [RW-1:0] d);
        wr(0, d);
        commit1();
    endtask

    task automatic done1();
        bus.i_layer_done = 1'b1;
        @(negedge clk);
        bus.i_layer_done = 1'b0;
    endtask

    task automatic wait_flag(input string name);
        bit seen = 0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            seen = bus.o_execution_flag;
        end
        chk(name, DW'(seen), DW'(1));
    endtask

    task automatic do_reset();
        bus.i_wr_en = 0; bus.i_commit = 0; bus.i_layer_done = 0; tb_loop = 0;
        resetn = 1'b0;
        @(negedge clk);
        resetn = 1'b1;
        obs_q.delete();
    endtask

    task automatic chk_obs(input string name, input int idx, input logic [33:0] exp);
        logic [33:0] got = '1;
        if (idx < obs_q.size()) got = obs_q[idx];
        chk(name, DW'(got), DW'(exp));
    endtask

    // ---------------- directed scenarios ----------------
    initial begin
        bus.i_wr_en = 0; bus.i_wr_addr = '0; bus.i_wr_data = '0;
        bus.i_commit = 0; bus.i_layer_done = 0;
        repeat (2) @(negedge clk);
        resetn = 1'b1;

        chk("rst_empty",  DW'(bus.o_empty), DW'(1));
        chk("rst_level",  DW'(bus.o_level), DW'(0));
        chk("rst_cfg",    bus.o_cfg, DW'(0));
        chk("rst_layers", DW'(bus.o_layers_done), DW'(0));

        // single entry: first strobe two cycles after commit
        wr(0, 32'hA5);
        commit1();
        chk("t1_no_early", DW'(bus.o_first_latching_condition), DW'(0));
        @(negedge clk);
        chk("t1_first",  DW'(bus.o_first_latching_condition), DW'(1));
        chk("t1_cfg",    DW'(bus.o_cfg[31:0]), DW'(32'hA5));
        @(negedge clk);
        chk("t1_flag",   DW'(bus.o_execution_flag), DW'(1));
        done1();
        chk("t1_layers", DW'(bus.o_layers_done), DW'(1));
        chk("t1_empty",  DW'(bus.o_empty), DW'(1));

        // three entries: first, update, update; staging word7 persists
        do_reset();
        wr(7, 32'h77);
        push_desc(32'hB1); push_desc(32'hB2); push_desc(32'hB3);
        for (int i = 0; i < 3; i++) begin
            wait_flag("t2_run");
            chk("t2_word7", DW'(bus.o_cfg[DW-1 -: 32]), DW'(32'h77));
            done1();
        end
        repeat (3) @(negedge clk);
        #1;
        chk("t2_nobs",   DW'(obs_q.size()), DW'(3));
        chk_obs("t2_s0", 0, {2'b10, 32'hB1});
        chk_obs("t2_s1", 1, {2'b01, 32'hB2});
        chk_obs("t2_s2", 2, {2'b01, 32'hB3});
        chk("t2_layers", DW'(bus.o_layers_done), DW'(3));
        chk("t2_empty",  DW'(bus.o_empty), DW'(1));
        chk("t2_flag",   DW'(bus.o_execution_flag), DW'(0));

        // overflow: fifth commit rejected
        do_reset();
        push_desc(32'hC0); push_desc(32'hC1); push_desc(32'hC2); push_desc(32'hC3);
        wr(0, 32'hC4);
        commit1();
        chk("t3_err",   DW'(bus.o_commit_err), DW'(1));
        chk("t3_level", DW'(bus.o_level), DW'(4));
        chk("t3_full",  DW'(bus.o_full), DW'(1));
        @(negedge clk);
        chk("t3_err_pulse", DW'(bus.o_commit_err), DW'(0));
        for (int i = 0; i < 4; i++) begin
            wait_flag("t3_run");
            done1();
        end
        repeat (4) @(negedge clk);
        #1;
        chk("t3_nobs", DW'(obs_q.size()), DW'(4));
        chk_obs("t3_s0", 0, {2'b10, 32'hC0});
        chk_obs("t3_s3", 3, {2'b01, 32'hC3});
        chk("t3_empty", DW'(bus.o_empty), DW'(1));

        // write in the commit cycle lands in staging, not the entry
        bus.i_wr_en = 1; bus.i_wr_addr = '0; bus.i_wr_data = 32'hF0; bus.i_commit = 1;
        @(negedge clk);
        bus.i_wr_en = 0; bus.i_commit = 0;
        wait_flag("t3b_run");
        chk("t3b_old", DW'(bus.o_cfg[31:0]), DW'(32'hC4));
        done1();
        commit1();
        wait_flag("t3c_run");
        chk("t3c_new", DW'(bus.o_cfg[31:0]), DW'(32'hF0));
        done1();

        // commit and retire together at level 2
        do_reset();
        push_desc(32'hD0); push_desc(32'hD1);
        wait_flag("t4_run");
        wr(0, 32'hD2);
        bus.i_commit = 1; bus.i_layer_done = 1;
        @(negedge clk);
        bus.i_commit = 0; bus.i_layer_done = 0;
        chk("t4_level",  DW'(bus.o_level), DW'(2));
        chk("t4_nostrb", DW'(bus.o_update_latching_condition), DW'(0));
        @(negedge clk);
        chk("t4_update", DW'(bus.o_update_latching_condition), DW'(1));
        chk("t4_cfg",    DW'(bus.o_cfg[31:0]), DW'(32'hD1));
        for (int i = 0; i < 2; i++) begin
            wait_flag("t4_drain");
            done1();
        end

        // reset mid-run restarts with a first strobe
        do_reset();
        push_desc(32'hE0);
        wait_flag("t5_run");
        wr(1, 32'h55);
        resetn = 1'b0;
        @(negedge clk);
        resetn = 1'b1;
        chk("t5_level", DW'(bus.o_level), DW'(0));
        chk("t5_flag",  DW'(bus.o_execution_flag), DW'(0));
        chk("t5_cfg",   bus.o_cfg, DW'(0));
        chk("t5_empty", DW'(bus.o_empty), DW'(1));
        wr(0, 32'hE1);
        commit1();
        @(negedge clk);
        chk("t5_first",  DW'(bus.o_first_latching_condition), DW'(1));
        chk("t5_noupd",  DW'(bus.o_update_latching_condition), DW'(0));
        chk("t5_word1",  DW'(bus.o_cfg[63:32]), DW'(0));
        wait_flag("t5_run2");
        done1();

`ifdef LAYER_CFG_LOOP_EN
        // replay: A,B rotate indefinitely; commits rejected while looping
        do_reset();
        push_desc(32'hAA); push_desc(32'hBB);
        tb_loop = 1;
        for (int i = 0; i < 5; i++) begin
            wait_flag("t6_run");
            done1();
        end
        wait_flag("t6_run_last");
        #1;
        chk("t6_nobs", DW'(obs_q.size()), DW'(6));
        for (int i = 0; i < 6; i++)
            chk_obs("t6_order", i, {(i == 0) ? 2'b10 : 2'b01, (i % 2 == 0) ? 32'hAA : 32'hBB});
        chk("t6_level", DW'(bus.o_level), DW'(2));
        chk("t6_layers", DW'(bus.o_layers_done), DW'(5));
        @(negedge clk);
        commit1();
        chk("t6_err", DW'(bus.o_commit_err), DW'(1));
        chk("t6_level2", DW'(bus.o_level), DW'(2));
        tb_loop = 0;
`endif

        repeat (3) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
